conv_mac: RTL

Sequential multiply-accumulate stage directly upstream of the Truncate stage in the convolution datapath. It accepts a stream of signed Q8.8 pixel/weight pairs, sums KERNEL_SIZE products plus a bias into an INTERNAL_BITS Q16.16 accumulator, and presents the full-precision sum with a valid/ready handshake. The downstream Truncate stage reduces that sum to DATA_BITS by taking bits [23:8].

---
 rtl/conv_mac_pkg.sv | 31 +++
 rtl/mac_mult.sv | 26 ++
 rtl/conv_mac.sv | 122 ++++++++++++
 3 files changed

// File: rtl/conv_mac_pkg.sv
// -----------------------------------------------------------------------------
// conv_mac_pkg
// Shared constants and types for the convolution multiply-accumulate stage.
// The CM_* constants are the datapath-wide operand/accumulator widths; the
// conv_mac parameters default to them.
//   CM_DATA_BITS     : operand width, signed Q8.8
//   CM_INTERNAL_BITS : accumulator width, signed Q16.16
//   CM_FRAC_BITS     : fractional bits of an operand
//   CM_KERNEL_SIZE   : default number of products per window
// -----------------------------------------------------------------------------
package conv_mac_pkg;

    localparam int CM_DATA_BITS     = 16;
    localparam int CM_INTERNAL_BITS = 32;
    localparam int CM_FRAC_BITS     = 8;
    localparam int CM_KERNEL_SIZE   = 9;

    // ST_ACC : collecting terms of a window (in_ready=1)
    // ST_HOLD: presenting the finished sum (out_valid=1)
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Term counter width; a one-term kernel still gets a 1-bit counter so
    // no zero-width vectors appear.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// -----------------------------------------------------------------------------
// mac_mult
// Combinational signed DATA_BITS x DATA_BITS multiplier. Kept as its own
// module so a pipelined or DSP-mapped multiplier can replace it.
//   a_i       : signed multiplicand
//   b_i       : signed multiplier
//   product_o : full-precision signed product (2*DATA_BITS bits)
// -----------------------------------------------------------------------------
module mac_mult #(
    parameter int DATA_BITS = 16
) (
    input  logic signed [DATA_BITS-1:0]   a_i,
    input  logic signed [DATA_BITS-1:0]   b_i,
    output logic signed [2*DATA_BITS-1:0] product_o
);

    logic signed [2*DATA_BITS-1:0] a_ext;
    logic signed [2*DATA_BITS-1:0] b_ext;

    // Operands are sign-extended to the product width first; the low
    // 2*DATA_BITS bits of the wide product equal the exact signed product.
    assign a_ext     = (2*DATA_BITS)'(a_i);
    assign b_ext     = (2*DATA_BITS)'(b_i);
    assign product_o = a_ext * b_ext;

endmodule

// File: rtl/conv_mac.sv
// -----------------------------------------------------------------------------
// conv_mac
// Sequential multiply-accumulate stage feeding the Truncate stage. Sums
// KERNEL_SIZE signed Q8.8 pixel*weight products plus a Q8.8 bias into a
// Q16.16 accumulator and presents the sum with a valid/ready handshake.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Both
// ready/valid outputs are pure decodes of the state register.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : abort current window (priority over both handshakes)
//   in_valid/in_ready : operand pair handshake
//   pixel, weight     : signed Q8.8 operands
//   bias              : signed Q8.8 bias, used with the first term of a window
//   out_valid/out_ready: result handshake
//   out_data          : signed Q16.16 window sum, stable while out_valid
//   dbg_state, dbg_cnt: FSM state and term counter for observation
// -----------------------------------------------------------------------------
module conv_mac
    import conv_mac_pkg::*;
#(
    parameter int DATA_BITS     = CM_DATA_BITS,
    parameter int INTERNAL_BITS = CM_INTERNAL_BITS,
    parameter int KERNEL_SIZE   = CM_KERNEL_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_BITS-1:0]                 pixel,
    input  logic [DATA_BITS-1:0]                 weight,
    input  logic [DATA_BITS-1:0]                 bias,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INTERNAL_BITS-1:0]             out_data,
    output state_e                               dbg_state,
    output logic [cnt_width(KERNEL_SIZE)-1:0]    dbg_cnt
);

    localparam int              CNT_W    = cnt_width(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_SIZE - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [INTERNAL_BITS-1:0]   acc_q, acc_d;

    logic signed [2*DATA_BITS-1:0] product;
    logic [INTERNAL_BITS-1:0]      prod_ext;
    logic [INTERNAL_BITS-1:0]      bias_ext;
    logic [INTERNAL_BITS-1:0]      acc_base;
    logic [INTERNAL_BITS-1:0]      acc_sum;

    mac_mult #(
        .DATA_BITS (DATA_BITS)
    ) u_mult (
        .a_i       ($signed(pixel)),
        .b_i       ($signed(weight)),
        .product_o (product)
    );

    // Bias is Q8.8; shifting by the fractional width aligns it to Q16.16.
    // The first term of a window starts from the bias instead of the old sum.
    always_comb begin
        prod_ext = INTERNAL_BITS'(product);
        bias_ext = INTERNAL_BITS'($signed(bias)) << CM_FRAC_BITS;
        acc_base = (cnt_q == '0) ? bias_ext : acc_q;
        acc_sum  = acc_base + prod_ext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (flush) begin
            // acc is left alone: cnt=0 makes the next term restart from bias.
            state_d = ST_ACC;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_d = acc_sum;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = acc_q;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule
